dot_product_stream: RTL and testbench
=====================================

Name: dot_product_stream

Overview:
- Streaming, parametrised dot-product engine; successor to the single-cycle fixed-size dot product.
- Accepts vectors of run-time length up to MAX_LEN as LANES elements per beat over a valid/ready handshake, multiplies lane-wise and accumulates across beats.
- Returns one accumulated result per job on a valid/ready output port.
- Sits between the vector operand buffers and the result register file of the accelerator datapath.

Parameters:
- DATA_WIDTH, 8, width of each unsigned element.
- LANES, 4, elements consumed per input beat.
- MAX_LEN, 256, maximum elements per job.
- LEN_WIDTH, 9, width of len port; must satisfy 2^LEN_WIDTH > MAX_LEN.
- ACC_WIDTH, 2*DATA_WIDTH+LEN_WIDTH, accumulator/result width; may be overridden smaller.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle job start; sampled only in IDLE.
- len, input, LEN_WIDTH, element count, sampled with start; values above MAX_LEN are clamped to MAX_LEN.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, engine accepts a beat.
- a_flat, input, LANES*DATA_WIDTH, lane i = a_flat[i*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the lowest element index.
- b_flat, input, LANES*DATA_WIDTH, same packing as a_flat.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, ACC_WIDTH, dot product.
- overflow, output, 1, accumulator exceeded ACC_WIDTH during the job; valid with out_valid.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, result=0, overflow=0, busy=0; state=IDLE. Pipeline registers, accumulator and beat counter are cleared.
- Reset mid-job: the job is abandoned and no result is produced.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start=1 and len>0 -> ACCUM; the accumulator is cleared and beats_left = ceil(len/LANES).
  - start=1 and len=0 -> DONE with result=0.
- ACCUM:
  - in_ready=1; a beat transfers on in_valid && in_ready.
  - In the final beat, lanes at index >= remaining element count are masked to zero.
  - After the final beat transfers -> DRAIN; in_ready drops on the next cycle.
- Pipeline:
  - Edge k (beat accepted): products registered at edge k+1.
  - Lane adder tree result added to the accumulator at edge k+2.
  - in_valid gaps insert bubbles that do not affect accumulation.
- DRAIN: waits until the pipeline is empty. result/out_valid are loaded at edge K+3, where K is the final-beat edge; -> DONE.
- DONE:
  - out_valid=1; result and overflow are held stable until out_valid && out_ready.
  - On that edge -> IDLE and out_valid=0.
- start outside IDLE is ignored; it is neither queued nor an error.
- Widths: products are 2*DATA_WIDTH bits; the adder tree grows to 2*DATA_WIDTH+clog2(LANES) bits.
- Overflow: accumulation is performed with one carry bit above ACC_WIDTH. Any carry out sets the sticky overflow bit for the job.
- Back-to-back jobs: minimum one IDLE cycle between out handshake and the next start.

Optional Feature:
- Macro: DOT_PRODUCT_SATURATE_EN.
- Defined: on overflow the accumulator clamps to 2^ACC_WIDTH-1 and holds there for the rest of the job; overflow=1.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH; overflow still reports the sticky carry.

Test Plan:
- Basic job, LANES=4: len=5, beats a={4,6,8,4}/b={3,9,1,5}, then a={2,x,x,x}/b={1,x,x,x} -> result=96, overflow=0, out_valid exactly 3 cycles after the 2nd beat edge; the x lanes are masked.
- Stalls: same job with in_valid low 2 cycles between beats and out_ready low 4 cycles -> result 96 held stable; single out handshake; returns to IDLE.
- len=0 start -> DONE next cycle, result=0, no beats consumed (in_ready stays 0).
- start pulsed while busy, plus reset asserted mid-ACCUM -> start ignored; after reset all outputs 0; a fresh job len=4 of all 1s gives result=4.
- Overflow, ACC_WIDTH=16, len=4, all elements 255:
  - macro defined -> result=65535, overflow=1.
  - macro undefined -> result=63492, overflow=1.
- MAX_LEN clamp: len=300, 64 beats of all 1s -> exactly 64 beats accepted, result=256.

Source files
------------

// File: rtl/dot_product_stream.sv
// rtl/dot_product_stream.sv - streaming lane-parallel dot-product engine.
// Define DOT_PRODUCT_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module dot_product_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int MAX_LEN    = 256,
  parameter int LEN_WIDTH  = 9,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+LEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] a_flat,
  input  logic [LANES*DATA_WIDTH-1:0] b_flat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        result,
  output logic                        overflow,
  output logic                        busy
);

  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int TREE_W = PROD_W + $clog2(LANES);
  localparam int SUM_W  = ((ACC_WIDTH > TREE_W) ? ACC_WIDTH : TREE_W) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                      state;
  logic [LEN_WIDTH-1:0]        rem;
  logic                        s0_valid;
  logic [LANES*DATA_WIDTH-1:0] a_r;
  logic [LANES*DATA_WIDTH-1:0] b_r;
  logic                        s1_valid;
  logic [PROD_W-1:0]           prod [LANES];
  logic [ACC_WIDTH-1:0]        acc;
  logic                        acc_ovf;

  logic [LEN_WIDTH-1:0]        len_eff;
  logic                        beat_fire;
  logic                        last_beat;
  logic [LANES*DATA_WIDTH-1:0] a_masked;
  logic [LANES*DATA_WIDTH-1:0] b_masked;
  logic [TREE_W-1:0]           tree;
  logic [SUM_W-1:0]            sum;
  logic                        carry;

  assign len_eff   = (len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len;
  assign beat_fire = in_valid && in_ready;
  // rem counts elements still owed, so the final beat is the one covering <= LANES of them
  assign last_beat = (rem <= LEN_WIDTH'(LANES));

  always_comb begin
    a_masked = '0;
    b_masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (LEN_WIDTH'(i) < rem) begin
        a_masked[i*DATA_WIDTH +: DATA_WIDTH] = a_flat[i*DATA_WIDTH +: DATA_WIDTH];
        b_masked[i*DATA_WIDTH +: DATA_WIDTH] = b_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) begin
      tree = tree + TREE_W'(prod[i]);
    end
  end

  // one spare bit above the wider operand catches any carry past ACC_WIDTH
  assign sum   = SUM_W'(acc) + SUM_W'(tree);
  assign carry = |sum[SUM_W-1:ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      s0_valid  <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      s1_valid  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod[i] <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s0_valid <= beat_fire;
      if (beat_fire) begin
        a_r <= a_masked;
        b_r <= b_masked;
      end

      s1_valid <= s0_valid;
      if (s0_valid) begin
        for (int i = 0; i < LANES; i++) begin
          prod[i] <= PROD_W'(a_r[i*DATA_WIDTH +: DATA_WIDTH]) * PROD_W'(b_r[i*DATA_WIDTH +: DATA_WIDTH]);
        end
      end

      if (s1_valid) begin
`ifdef DOT_PRODUCT_SATURATE_EN
        if (acc_ovf || carry) acc <= '1;
        else                  acc <= sum[ACC_WIDTH-1:0];
`else
        acc <= sum[ACC_WIDTH-1:0];
`endif
        acc_ovf <= acc_ovf | carry;
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len_eff != '0) begin
              state    <= ACCUM;
              rem      <= len_eff;
              in_ready <= 1'b1;
              acc      <= '0;
              acc_ovf  <= 1'b0;
            end else begin
              state     <= DONE;
              result    <= '0;
              overflow  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat_fire) begin
            if (last_beat) begin
              rem      <= '0;
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else begin
              rem <= rem - LEN_WIDTH'(LANES);
            end
          end
        end
        DRAIN: begin
          if (!s0_valid && !s1_valid) begin
            result    <= acc;
            overflow  <= acc_ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_stream.sv
// tb/tb_dot_product_stream.sv - checks dot_product_stream (default and 16-bit accumulator) against an arithmetic model.
module tb_dot_product_stream;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int LW = 9;
  localparam int AW = 25;
  localparam int AS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic [LN*DW-1:0] a_flat = '0;
  logic [LN*DW-1:0] b_flat = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, overflow, busy;
  logic [AW-1:0] result;
  logic          in_ready_s, out_valid_s, overflow_s, busy_s;
  logic [AS-1:0] result_s;

  int compared = 0;
  int mismatched = 0;
  int a_el [512];
  int b_el [512];

  dot_product_stream dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .busy(busy)
  );

  dot_product_stream #(.ACC_WIDTH(AS)) dut_s (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_s), .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
    .overflow(overflow_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    compared++;
    mismatched++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // exact dot product over the first e elements, then reduced to a w-bit accumulator
  function automatic void model(input int e, input int w, output logic [63:0] res, output logic ov);
    longint s = 0;
    longint lim = longint'(1) << w;
    for (int i = 0; i < e; i++) s += longint'(a_el[i]) * longint'(b_el[i]);
    ov = (s >= lim);
`ifdef DOT_PRODUCT_SATURATE_EN
    res = ov ? 64'(lim - 1) : 64'(s);
`else
    res = 64'(s % lim);
`endif
  endfunction

  task automatic do_job(input int l, input int gap, input int ostall, input bit poke);
    int e, nb, c, idx;
    logic [63:0] r_d, r_s;
    logic o_d, o_s;
    e  = (l > 256) ? 256 : l;
    nb = (e + LN - 1) / LN;
    start = 1'b1;
    len   = LW'(l);
    cyc();
    start = 1'b0;
    if (e == 0) begin
      chk("len0_out_valid", 64'(out_valid), 64'd1);
      chk("len0_in_ready", 64'(in_ready), 64'd0);
    end else begin
      for (int j = 0; j < nb; j++) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          if (poke && j == 1 && g == 0) begin
            start = 1'b1;
            len   = 9'd3;
          end
          cyc();
          start = 1'b0;
        end
        in_valid = 1'b1;
        for (int k = 0; k < LN; k++) begin
          idx = j*LN + k;
          a_flat[k*DW +: DW] = (idx < e) ? DW'(a_el[idx]) : DW'($urandom);
          b_flat[k*DW +: DW] = (idx < e) ? DW'(b_el[idx]) : DW'($urandom);
        end
        c = 0;
        while (!in_ready && c < 10) begin
          cyc();
          c++;
        end
        if (c >= 10) timeout("in_ready_wait");
        cyc();
      end
      in_valid = 1'b0;
      chk("in_ready_after_last", 64'(in_ready), 64'd0);
      c = 0;
      while (!out_valid && c < 20) begin
        cyc();
        c++;
      end
      chk("out_latency", 64'(c), 64'd3);
    end
    model(e, AW, r_d, o_d);
    model(e, AS, r_s, o_s);
    chk("result", 64'(result), r_d);
    chk("overflow", 64'(overflow), 64'(o_d));
    chk("result_acc16", 64'(result_s), r_s);
    chk("overflow_acc16", 64'(overflow_s), 64'(o_s));
    out_ready = 1'b0;
    for (int s = 0; s < ostall; s++) begin
      if (poke && s == 0) begin
        start = 1'b1;
        len   = 9'd5;
      end
      cyc();
      start = 1'b0;
    end
    if (ostall > 0) begin
      chk("held_valid", 64'(out_valid), 64'd1);
      chk("held_result", 64'(result), r_d);
      chk("held_result_acc16", 64'(result_s), r_s);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("post_handshake_valid", 64'(out_valid), 64'd0);
    chk("post_handshake_busy", 64'(busy), 64'd0);
    chk("post_handshake_busy_acc16", 64'(busy_s), 64'd0);
    cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    a_el[0:4] = '{4, 6, 8, 4, 2};
    b_el[0:4] = '{3, 9, 1, 5, 1};
    do_job(5, 0, 0, 1'b0);
    chk("basic_literal", 64'(result), 64'd96);
    do_job(5, 2, 4, 1'b1);
    do_job(0, 0, 2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      a_el[i] = i + 1;
      b_el[i] = 2;
    end
    start = 1'b1;
    len   = 9'd8;
    cyc();
    start    = 1'b0;
    in_valid = 1'b1;
    a_flat   = 32'h04030201;
    b_flat   = 32'h02020202;
    cyc();
    in_valid = 1'b0;
    rst      = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid || busy) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    for (int i = 0; i < 4; i++) begin
      a_el[i] = 1;
      b_el[i] = 1;
    end
    do_job(4, 1, 0, 1'b0);
    chk("fresh_literal", 64'(result), 64'd4);

    for (int i = 0; i < 4; i++) begin
      a_el[i] = 255;
      b_el[i] = 255;
    end
    do_job(4, 0, 1, 1'b0);
`ifdef DOT_PRODUCT_SATURATE_EN
    chk("ovf16_literal", 64'(result_s), 64'd65535);
`else
    chk("ovf16_literal", 64'(result_s), 64'd63492);
`endif
    chk("ovf16_flag_literal", 64'(overflow_s), 64'd1);

    for (int i = 0; i < 300; i++) begin
      a_el[i] = 1;
      b_el[i] = 1;
    end
    do_job(300, 0, 0, 1'b0);
    chk("clamp_literal", 64'(result), 64'd256);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 300; i++) begin
        a_el[i] = int'($urandom_range(0, 255));
        b_el[i] = int'($urandom_range(0, 255));
      end
      do_job(int'($urandom_range(0, 300)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
